// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - operation codes, decode helpers and divider states for muldiv_unit
//
// Contents:
//   muldiv_op_e  4-bit HI/LO operation codes
//   div_state_e  divider FSM states
//   is_hilo_op   1 for every code that reads or writes HI/LO
//   is_mul_op    1 for every code that goes through the multiplier pipeline
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_MFHI  = 4'd10,
    OP_MFLO  = 4'd11,
    OP_NONE  = 4'd15
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Codes are laid out so that the HI/LO group and the multiplier group
  // are contiguous ranges starting at zero.
  function automatic logic is_hilo_op(input logic [3:0] op);
    return op <= OP_MFLO;
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return op <= OP_MSUBU;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// rtl/muldiv_divider.sv - iterative restoring divider with sign pre/post processing
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_i                  begin a divide (only honoured in IDLE)
//   signed_i                 operands are two's complement (DIV) rather than unsigned (DIVU)
//   abort_i                  drop the divide in progress and return to IDLE
//   a_i, b_i                 dividend, divisor
//   busy_o                   a divide is in RUN or FIX
//   done_o                   quotient_o/remainder_o are final this cycle (FIX)
//   quotient_o, remainder_o  sign-corrected results
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             zero_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];
  // |MIN| wraps to MIN, which read as unsigned is the correct magnitude.
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  // The dividend is shifted out of quo_q into the partial remainder while
  // quotient bits are shifted in from the bottom. diff[WIDTH] is the borrow.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            quo_q   <= a_abs;
            rem_q   <= '0;
            dvs_q   <= b_abs;
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            zero_q  <= (b_i == '0);
          end
        end
        RUN: begin
          if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == FIX) & ~abort_i;

  // A zero divisor leaves |dividend| in rem_q; giving it the dividend's sign
  // restores the raw dividend. The quotient is forced to all ones so that a
  // signed divide by zero does not get negated.
  assign quotient_o  = zero_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign remainder_o = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with pipelined multiplier and iterative divider
//
// Ports:
//   clock, reset   clock, synchronous active-low reset
//   Op_Valid, Op   EX stage holds a muldiv operation and its code
//   Commit         the operation may take effect
//   Abort          cancel all in-flight multiply/divide work
//   A, B           rs / rt operands
//   Result         HI or LO for MFHI/MFLO, zero otherwise
//   Busy           divider or multiplier pipeline non-empty
//   Stall_Req      combinational HI/LO hazard stall
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Op_Valid,
  input  logic [3:0]       Op,
  input  logic             Commit,
  input  logic             Abort,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Stall_Req
);

  localparam int DW = 2 * WIDTH;

  logic [DW-1:0]    hilo_q;
  logic [DW-1:0]    hilo_d;
  logic             accept;
  logic             mul_acc;
  logic             div_start;
  logic             mul_busy;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             mul_signed;
  logic [DW-1:0]    a_ext;
  logic [DW-1:0]    b_ext;
  logic [DW-1:0]    prod_in;
  logic             ret_vld;
  logic [DW-1:0]    ret_prod;
  logic [3:0]       ret_op;

  // Back-to-back MULT/MULTU may follow anything in the multiplier because
  // they overwrite HILO; everything else must wait for it to drain.
  assign Stall_Req = Op_Valid &
                     ((div_busy & is_hilo_op(Op)) |
                      (mul_busy & (Op != OP_MULT) & (Op != OP_MULTU)));

  assign accept    = Op_Valid & Commit & ~Stall_Req & ~Abort;
  assign mul_acc   = accept & is_mul_op(Op);
  assign div_start = accept & ((Op == OP_DIV) | (Op == OP_DIVU));

  // Extending both operands to 2*WIDTH makes the low 2*WIDTH bits of a plain
  // product the exact signed or unsigned result.
  assign mul_signed = (Op == OP_MULT) | (Op == OP_MADD) | (Op == OP_MSUB);
  assign a_ext      = {{WIDTH{mul_signed & A[WIDTH-1]}}, A};
  assign b_ext      = {{WIDTH{mul_signed & B[WIDTH-1]}}, B};
  assign prod_in    = a_ext * b_ext;

  // HILO is the last of the MUL_LATENCY registers, so only MUL_LATENCY-1
  // stages sit in front of it.
  generate
    if (MUL_LATENCY == 1) begin : g_mul_direct
      assign ret_vld  = mul_acc;
      assign ret_prod = prod_in;
      assign ret_op   = Op;
      assign mul_busy = 1'b0;
    end else begin : g_mul_pipe
      localparam int NS = MUL_LATENCY - 1;

      logic [NS-1:0] vld_q;
      logic [DW-1:0] prod_q [NS];
      logic [3:0]    op_q   [NS];

      always_ff @(posedge clock) begin
        if (!reset || Abort) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= mul_acc;
          for (int i = 1; i < NS; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      always_ff @(posedge clock) begin
        prod_q[0] <= prod_in;
        op_q[0]   <= Op;
        for (int i = 1; i < NS; i++) begin
          prod_q[i] <= prod_q[i-1];
          op_q[i]   <= op_q[i-1];
        end
      end

      assign ret_vld  = vld_q[NS-1];
      assign ret_prod = prod_q[NS-1];
      assign ret_op   = op_q[NS-1];
      assign mul_busy = |vld_q;
    end
  endgenerate

  muldiv_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk_i       (clock),
    .rst_ni      (reset),
    .start_i     (div_start),
    .signed_i    (Op == OP_DIV),
    .abort_i     (Abort),
    .a_i         (A),
    .b_i         (B),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // The stall rule keeps retire, divide completion and MTHI/MTLO mutually
  // exclusive, so the order of the writes below never matters.
  always_comb begin
    hilo_d = hilo_q;
    if (!Abort) begin
      if (ret_vld) begin
        case (ret_op)
          OP_MADD, OP_MADDU: hilo_d = hilo_q + ret_prod;
          OP_MSUB, OP_MSUBU: hilo_d = hilo_q - ret_prod;
          default:           hilo_d = ret_prod;
        endcase
      end
      if (div_done) begin
        hilo_d = {div_rem, div_quo};
      end
      if (accept && (Op == OP_MTHI)) begin
        hilo_d[DW-1:WIDTH] = A;
      end
      if (accept && (Op == OP_MTLO)) begin
        hilo_d[WIDTH-1:0] = A;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  always_comb begin
    Result = '0;
    if (Op_Valid) begin
      if (Op == OP_MFHI) begin
        Result = hilo_q[DW-1:WIDTH];
      end else if (Op == OP_MFLO) begin
        Result = hilo_q[WIDTH-1:0];
      end
    end
  end

  assign Busy = mul_busy | div_busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int L = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         Op_Valid = 1'b0;
  logic [3:0]   Op = 4'd15;
  logic         Commit = 1'b0;
  logic         Abort = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Result;
  logic         Busy;
  logic         Stall_Req;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  muldiv_unit #(
    .WIDTH(W),
    .MUL_LATENCY(L)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Op_Valid  (Op_Valid),
    .Op        (Op),
    .Commit    (Commit),
    .Abort     (Abort),
    .A         (A),
    .B         (B),
    .Result    (Result),
    .Busy      (Busy),
    .Stall_Req (Stall_Req)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           vis;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } ent_t;

  ent_t         pq[$];
  logic [63:0]  arch = '0;
  int           cyc = 0;
  bit           prev_rst = 1'b0;

  function automatic logic [63:0] mul_prod(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (op == OP_MULT || op == OP_MADD || op == OP_MSUB) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [63:0] div_res(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int sa, sb;
    logic [W-1:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (op == OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic apply(input ent_t e);
    case (e.op)
      OP_MADD, OP_MADDU: arch = arch + mul_prod(e.op, e.a, e.b);
      OP_MSUB, OP_MSUBU: arch = arch - mul_prod(e.op, e.a, e.b);
      OP_MULT, OP_MULTU: arch = mul_prod(e.op, e.a, e.b);
      OP_DIV, OP_DIVU:   arch = div_res(e.op, e.a, e.b);
      OP_MTHI:           arch[63:32] = e.a;
      OP_MTLO:           arch[31:0] = e.a;
      default:           arch = arch;
    endcase
  endtask

  always @(negedge clock) begin
    bit dp, mp, es;
    logic [W-1:0] er;
    ent_t e;
    cyc++;
    if (!reset) begin
      if (prev_rst) begin
        check("reset_busy", Busy, 0);
        check("reset_stall", Stall_Req, 0);
        check("reset_result", Result, 0);
      end
      pq.delete();
      arch = '0;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      while (pq.size() > 0 && pq[0].vis <= cyc) begin
        apply(pq[0]);
        void'(pq.pop_front());
      end
      dp = 1'b0;
      mp = 1'b0;
      foreach (pq[i]) begin
        if (pq[i].op == OP_DIV || pq[i].op == OP_DIVU) dp = 1'b1;
        else mp = 1'b1;
      end
      es = Op_Valid && ((dp && Op <= OP_MFLO) || (mp && Op != OP_MULT && Op != OP_MULTU));
      er = '0;
      if (Op_Valid && Op == OP_MFHI) er = arch[63:32];
      else if (Op_Valid && Op == OP_MFLO) er = arch[31:0];
      check("busy", Busy, 64'(pq.size() > 0));
      check("stall", Stall_Req, 64'(es));
      check("result", Result, er);
      if (Abort) begin
        pq.delete();
      end else if (Op_Valid && Commit && !es) begin
        e.op = Op;
        e.a = A;
        e.b = B;
        e.vis = -1;
        if (Op <= OP_MSUBU) e.vis = cyc + L;
        else if (Op == OP_DIV || Op == OP_DIVU) e.vis = cyc + W + 2;
        else if (Op == OP_MTHI || Op == OP_MTLO) e.vis = cyc + 1;
        if (e.vis >= 0) pq.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit do_chk, input logic [W-1:0] exp, input string nm,
                       output int n);
    Op_Valid = 1'b1;
    Commit = 1'b1;
    Op = op;
    A = a;
    B = b;
    n = 0;
    @(negedge clock);
    while (Stall_Req === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout op %0d: stalled %0d cycles, required to clear", op, n);
    end
    if (do_chk) check(nm, Result, exp);
    @(posedge clock);
    #1;
    Op_Valid = 1'b0;
    Commit = 1'b0;
    Op = OP_NONE;
  endtask

  task automatic op2(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    issue(op, a, b, 1'b0, '0, "", n);
  endtask

  task automatic rd(input logic [3:0] op, input logic [W-1:0] exp, input string nm,
                    output int n);
    issue(op, '0, '0, 1'b1, exp, nm, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    rd(OP_MFHI, 32'h0, "reset_hi", n);
    rd(OP_MFLO, 32'h0, "reset_lo", n);

    op2(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    rd(OP_MFLO, 32'hFFFF_FFEB, "mult_lo", n);
    check("mult_mflo_stall_cycles", n, 1);
    rd(OP_MFHI, 32'hFFFF_FFFF, "mult_hi", n);

    op2(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    issue(OP_MULT, 32'd5, 32'd6, 1'b0, '0, "", n);
    check("b2b_mult_stall_cycles", n, 0);
    rd(OP_MFLO, 32'd30, "b2b_lo", n);
    check("b2b_mflo_stall_cycles", n, 1);
    rd(OP_MFHI, 32'd0, "b2b_hi", n);

    op2(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    rd(OP_MFLO, 32'hFFFF_FFFD, "div_lo", n);
    check("div_mflo_stall_cycles", n, 33);
    rd(OP_MFHI, 32'hFFFF_FFFF, "div_hi", n);

    op2(OP_DIVU, 32'h1234, 32'd0);
    rd(OP_MFLO, 32'hFFFF_FFFF, "divu0_lo", n);
    rd(OP_MFHI, 32'h1234, "divu0_hi", n);

    op2(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    rd(OP_MFLO, 32'h8000_0000, "divmin_lo", n);
    rd(OP_MFHI, 32'h0, "divmin_hi", n);

    op2(OP_DIVU, 32'd100, 32'd7);
    rd(OP_MFLO, 32'd14, "divu_lo", n);
    rd(OP_MFHI, 32'd2, "divu_hi", n);

    op2(OP_MTHI, 32'd5, 32'd0);
    op2(OP_MTLO, 32'd10, 32'd0);
    op2(OP_MADDU, 32'd3, 32'd4);
    rd(OP_MFHI, 32'd5, "maddu_hi", n);
    rd(OP_MFLO, 32'h16, "maddu_lo", n);
    op2(OP_MSUB, 32'd1, 32'd2);
    rd(OP_MFLO, 32'h14, "msub_lo", n);
    rd(OP_MFHI, 32'd5, "msub_hi", n);

    op2(OP_DIV, 32'd100, 32'd3);
    step(9);
    Abort = 1'b1;
    step(1);
    Abort = 1'b0;
    @(negedge clock);
    check("abort_div_busy", Busy, 0);
    step(1);
    rd(OP_MFHI, 32'd5, "abort_div_hi", n);
    rd(OP_MFLO, 32'h14, "abort_div_lo", n);

    Op_Valid = 1'b1;
    Commit = 1'b1;
    Op = OP_MULT;
    A = 32'd9;
    B = 32'd9;
    Abort = 1'b1;
    step(1);
    Op_Valid = 1'b0;
    Commit = 1'b0;
    Abort = 1'b0;
    @(negedge clock);
    check("abort_mul_busy", Busy, 0);
    step(1);
    rd(OP_MFLO, 32'h14, "abort_mul_lo", n);
    rd(OP_MFHI, 32'd5, "abort_mul_hi", n);

    Op_Valid = 1'b1;
    Commit = 1'b0;
    Op = OP_MTLO;
    A = 32'd77;
    step(1);
    Op_Valid = 1'b0;
    rd(OP_MFLO, 32'h14, "nocommit_lo", n);

    op2(OP_MTHI, 32'd0, 32'd0);
    op2(OP_MTLO, 32'd0, 32'd0);
    op2(OP_MADD, 32'hFFFF_FFFE, 32'd3);
    op2(OP_MSUBU, 32'd1, 32'd1);
    rd(OP_MFLO, 32'hFFFF_FFF9, "madd_msubu_lo", n);
    rd(OP_MFHI, 32'hFFFF_FFFF, "madd_msubu_hi", n);

    op2(OP_DIV, 32'd50, 32'd7);
    step(5);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_busy", Busy, 0);
    step(1);
    rd(OP_MFHI, 32'd0, "post_reset_hi", n);
    rd(OP_MFLO, 32'd0, "post_reset_lo", n);
    op2(OP_MULT, 32'd2, 32'd3);
    rd(OP_MFLO, 32'd6, "post_reset_mult_lo", n);
    rd(OP_MFHI, 32'd0, "post_reset_mult_hi", n);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
